// File: rtl/ctrl_pipe.sv
// Pipeline control carrier: moves decoded controls through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards, injects bubbles on stall/flush and selects EX forwarding sources.
module ctrl_pipe #(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regdst,
    input  logic            jump,
    input  logic            branch_beq,
    input  logic            branch_bne,
    input  logic            memread,
    input  logic            memtoreg,
    input  logic            memwrite,
    input  logic            regwrite,
    input  logic            alusrc,
    input  logic [1:0]      aluop,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            if_flush,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_branch_beq,
    output logic            ex_branch_bne,
    output logic [1:0]      ex_aluop,
    output logic [REGW-1:0] ex_rs,
    output logic [REGW-1:0] ex_rt,
    output logic [REGW-1:0] ex_dst,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_memtoreg,
    output logic            mem_regwrite,
    output logic            mem_branch_beq,
    output logic            mem_branch_bne,
    output logic [REGW-1:0] mem_dst,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic [REGW-1:0] wb_dst,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic            id_uses_rt;
    logic            hazard;
    logic [REGW-1:0] ex_rd;

    // ID stage: hazard detection and fetch squash
    assign id_uses_rt = regdst | branch_beq | branch_bne | memwrite;
    assign hazard     = ex_memread && (ex_dst != '0) &&
                        ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    assign stall      = hazard & ~flush;
    assign if_flush   = (jump & ~stall) | flush;

    // ID/EX register
    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_regdst     <= 1'b0;
            ex_alusrc     <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_memtoreg   <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_branch_beq <= 1'b0;
            ex_branch_bne <= 1'b0;
            ex_aluop      <= 2'b00;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
        end else begin
            ex_regdst     <= regdst;
            ex_alusrc     <= alusrc;
            ex_memread    <= memread;
            ex_memwrite   <= memwrite;
            ex_memtoreg   <= memtoreg;
            ex_regwrite   <= regwrite;
            ex_branch_beq <= branch_beq;
            ex_branch_bne <= branch_bne;
            ex_aluop      <= aluop;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
        end
    end

    assign ex_dst = ex_regdst ? ex_rd : ex_rt;

    // EX/MEM register; writes to r0 are dropped here so later stages never forward them
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_memtoreg   <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_branch_beq <= 1'b0;
            mem_branch_bne <= 1'b0;
            mem_dst        <= '0;
        end else begin
            mem_memread    <= ex_memread;
            mem_memwrite   <= ex_memwrite;
            mem_memtoreg   <= ex_memtoreg;
            mem_regwrite   <= ex_regwrite & (ex_dst != '0);
            mem_branch_beq <= ex_branch_beq;
            mem_branch_bne <= ex_branch_bne;
            mem_dst        <= ex_dst;
        end
    end

    // MEM/WB register: never flushed, the resolving branch itself commits
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_memtoreg <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_dst      <= '0;
        end else begin
            wb_memtoreg <= mem_memtoreg;
            wb_regwrite <= mem_regwrite;
            wb_dst      <= mem_dst;
        end
    end

    // EX forwarding: MEM result beats WB; a load in MEM has no data yet
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_dst == ex_rs) && !mem_memread)
            fwd_a = 2'b10;
        else if (wb_regwrite && (wb_dst == ex_rs))
            fwd_a = 2'b01;
        if (mem_regwrite && (mem_dst == ex_rt) && !mem_memread)
            fwd_b = 2'b10;
        else if (wb_regwrite && (wb_dst == ex_rt))
            fwd_b = 2'b01;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed-vector bench for ctrl_pipe; expected values are hand-computed per vector.
module tb_ctrl_pipe;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            regdst, jump, branch_beq, branch_bne, memread, memtoreg, memwrite, regwrite, alusrc;
    logic [1:0]      aluop;
    logic [REGW-1:0] id_rs, id_rt, id_rd;
    logic            flush;
    logic            stall, if_flush;
    logic            ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic            ex_branch_beq, ex_branch_bne;
    logic [1:0]      ex_aluop;
    logic [REGW-1:0] ex_rs, ex_rt, ex_dst;
    logic            mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_branch_beq, mem_branch_bne;
    logic [REGW-1:0] mem_dst;
    logic            wb_memtoreg, wb_regwrite;
    logic [REGW-1:0] wb_dst;
    logic [1:0]      fwd_a, fwd_b;

    int vectors = 0;
    int miscompares = 0;

    ctrl_pipe #(.REGW(REGW)) dut (
        .clk(clk), .reset(reset),
        .regdst(regdst), .jump(jump), .branch_beq(branch_beq), .branch_bne(branch_bne),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .regwrite(regwrite),
        .alusrc(alusrc), .aluop(aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .stall(stall), .if_flush(if_flush),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_branch_beq(ex_branch_beq), .ex_branch_bne(ex_branch_bne), .ex_aluop(ex_aluop),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_branch_beq(mem_branch_beq), .mem_branch_bne(mem_branch_bne),
        .mem_dst(mem_dst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // Packed views of the stage registers for whole-stage comparisons
    logic [9:0]  ex_ctl;
    logic [5:0]  mem_ctl;
    logic [31:0] all_regs;
    assign ex_ctl   = {ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite,
                       ex_branch_beq, ex_branch_bne, ex_aluop};
    assign mem_ctl  = {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_branch_beq, mem_branch_bne};
    assign all_regs = {ex_ctl, mem_ctl, wb_memtoreg, wb_regwrite, 14'(ex_rs ^ ex_rt ^ ex_dst ^ mem_dst ^ wb_dst)};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        {regdst, jump, branch_beq, branch_bne, memread, memtoreg, memwrite, regwrite, alusrc} = '0;
        aluop = 2'b00;
        id_rs = '0; id_rt = '0; id_rd = '0;
        #1;
    endtask

    task automatic rtype(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt, input logic [REGW-1:0] rd);
        nop();
        regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10;
        id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic lw(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt);
        nop();
        memread = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; alusrc = 1'b1;
        id_rs = rs; id_rt = rt;
        #1;
    endtask

    task automatic addi(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt);
        nop();
        regwrite = 1'b1; alusrc = 1'b1;
        id_rs = rs; id_rt = rt;
        #1;
    endtask

    task automatic sw(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt);
        nop();
        memwrite = 1'b1; alusrc = 1'b1;
        id_rs = rs; id_rt = rt;
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    initial begin
        flush = 1'b0;
        reset = 1'b1;
        lw(5'd3, 5'd5);
        repeat (2) step();
        check_val("reset_regs", 32'(all_regs), 32'd0);
        check_val("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check_val("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        drain();

        // Plain flow of an R-type
        rtype(5'd1, 5'd2, 5'd3);
        step();
        nop();
        check_val("flow_ex_dst", 32'(ex_dst), 32'd3);
        check_val("flow_ex_aluop", 32'(ex_aluop), 32'd2);
        step();
        check_val("flow_mem_rw", 32'(mem_regwrite), 32'd1);
        check_val("flow_mem_dst", 32'(mem_dst), 32'd3);
        step();
        check_val("flow_wb_rw", 32'(wb_regwrite), 32'd1);
        check_val("flow_wb_dst", 32'(wb_dst), 32'd3);
        drain();

        // Load-use on rs
        lw(5'd0, 5'd5);
        step();
        rtype(5'd5, 5'd6, 5'd7);
        check_val("lu_rs_stall", 32'(stall), 32'd1);
        step();
        check_val("lu_rs_bubble", 32'(ex_ctl), 32'd0);
        check_val("lu_rs_stall_1cyc", 32'(stall), 32'd0);
        step();
        check_val("lu_rs_ex_rs", 32'(ex_rs), 32'd5);
        check_val("lu_rs_fwd_a", 32'(fwd_a), 32'd1);
        check_val("lu_rs_fwd_b", 32'(fwd_b), 32'd0);
        drain();

        // Load-use on rt: addi ignores rt, sw reads it
        lw(5'd0, 5'd4);
        step();
        addi(5'd7, 5'd4);
        check_val("lu_rt_addi", 32'(stall), 32'd0);
        sw(5'd7, 5'd4);
        check_val("lu_rt_sw", 32'(stall), 32'd1);
        drain();

        // Load into r0 never stalls
        lw(5'd0, 5'd0);
        step();
        rtype(5'd0, 5'd0, 5'd1);
        check_val("lu_r0_stall", 32'(stall), 32'd0);
        drain();

        // Forwarding priority: MEM wins over WB
        rtype(5'd1, 5'd2, 5'd6);
        step();
        rtype(5'd1, 5'd2, 5'd6);
        step();
        rtype(5'd6, 5'd6, 5'd8);
        step();
        nop();
        check_val("fwd_prio_a", 32'(fwd_a), 32'd2);
        check_val("fwd_prio_b", 32'(fwd_b), 32'd2);
        drain();

        // Write to r0 suppressed
        rtype(5'd1, 5'd2, 5'd0);
        step();
        rtype(5'd0, 5'd0, 5'd9);
        step();
        nop();
        check_val("r0_mem_rw", 32'(mem_regwrite), 32'd0);
        check_val("r0_fwd_a", 32'(fwd_a), 32'd0);
        drain();

        // Flush together with a load-use hazard, then a second flush
        lw(5'd0, 5'd5);
        step();
        rtype(5'd5, 5'd6, 5'd7);
        flush = 1'b1;
        #1;
        check_val("flush_stall", 32'(stall), 32'd0);
        check_val("flush_if_flush", 32'(if_flush), 32'd1);
        step();
        check_val("flush_ex", 32'({ex_ctl, ex_dst}), 32'd0);
        check_val("flush_mem", 32'({mem_ctl, mem_dst}), 32'd0);
        step();
        check_val("flush2_ex", 32'(ex_ctl), 32'd0);
        check_val("flush2_mem", 32'(mem_ctl), 32'd0);
        flush = 1'b0;
        drain();

        // Jump in ID
        nop();
        jump = 1'b1; aluop = 2'b10;
        #1;
        check_val("jump_if_flush", 32'(if_flush), 32'd1);
        check_val("jump_stall", 32'(stall), 32'd0);
        step();
        nop();
        check_val("jump_ex_ctl", 32'(ex_ctl), 32'h002);
        drain();

        // Reset mid-stream drops in-flight bundles
        rtype(5'd1, 5'd2, 5'd3);
        step();
        rtype(5'd4, 5'd5, 5'd6);
        step();
        reset = 1'b1;
        step();
        check_val("midreset_regs", 32'(all_regs), 32'd0);
        reset = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the opcode decoder down the pipeline through the ID/EX, EX/MEM and MEM/WB stage registers, dropping each signal once its last consumer stage has used it. It detects load-use hazards and produces the IF/ID stall. It injects bubbles on stall and on branch/jump flush, and produces EX-stage forwarding selects. It sits between the ID-stage decoder and the EX/MEM/WB datapath.

## Interface
Parameters:
- REGW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-high; clears every stage register
- regdst, jump, branch_beq, branch_bne, memread, memtoreg, memwrite, regwrite, alusrc  in  1 each  ID-stage decoded controls
- aluop  in  2  ID-stage ALU op class
- id_rs, id_rt, id_rd  in  REGW  ID-stage register fields
- flush  in  1  branch taken (resolved in MEM); squash ID and EX instructions
- stall  out  1  hold PC and IF/ID this cycle
- if_flush  out  1  squash the fetched instruction (jump in ID, or flush)
- ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch_beq, ex_branch_bne  out  1 each  ID/EX register
- ex_aluop  out  2  ID/EX register
- ex_rs, ex_rt, ex_dst  out  REGW  ID/EX fields; ex_dst = ex_regdst ? rd : rt
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_branch_beq, mem_branch_bne  out  1 each  EX/MEM register
- mem_dst  out  REGW
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB register
- wb_dst  out  REGW
- fwd_a, fwd_b  out  2  EX operand select: 2'b10 from MEM, 2'b01 from WB, 2'b00 register file

## Operation
- id_uses_rt = regdst | branch_beq | branch_bne | memwrite.
- hazard = ex_memread & (ex_dst != 0) & ((ex_dst == id_rs) | (id_uses_rt & ex_dst == id_rt)).
- stall = hazard & ~flush. Combinational.
- if_flush = (jump & ~stall) | flush.
- ID/EX load: a bubble loads when stall or flush. A bubble clears all control bits, aluop and the register fields. Otherwise the register loads the ID inputs.
- EX/MEM load: a bubble loads when flush. Otherwise it loads the EX controls.
  - mem_regwrite = ex_regwrite & (ex_dst != 0), so r0 writes are suppressed here.
- MEM/WB load: always loads from MEM. It is never flushed, because the branch in MEM is itself committed.
- Forwarding, fwd_a (rs):
  - 2'b10 if mem_regwrite & mem_dst == ex_rs & ~mem_memread.
  - Else 2'b01 if wb_regwrite & wb_dst == ex_rs.
  - Else 2'b00.
- Forwarding, fwd_b: same rule with ex_rt. MEM has priority over WB.
- Precedence: reset > flush > stall > normal load.
- Jump in ID needs no bubble. The jump's own control bits (all zero except aluop = 2'b10) pass into EX unchanged.

## Timing
- All stage registers update on the rising edge of clk.
- Reset is synchronous. After the first edge with reset high, every registered output is 0.
  - fwd_a and fwd_b then read 2'b00.
  - stall and if_flush reduce to their combinational terms from the current inputs (jump, flush, and the ID fields compared against ex_dst = 0).
- Reset asserted mid-stream discards all in-flight bundles at that edge, with no partial commit.
- Latency: an ID bundle appears on ex_* 1 cycle later, on mem_* 2 cycles later, and on wb_* 3 cycles later, absent bubbles.
- stall, if_flush, fwd_a and fwd_b are combinational in the same cycle as their inputs.
- A load-use stall lasts exactly 1 cycle. The next cycle ex_memread = 0 (bubble), so the hazard clears, and WB/MEM forwarding covers the dependency.
- If flush and hazard occur together: stall = 0, and ID/EX and EX/MEM both take bubbles.
- Back-to-back flushes: each cycle bubbles both stages, with no accumulated state.

## Test plan
- Reset: hold reset 2 cycles with arbitrary inputs -> every ex_*, mem_* and wb_* output = 0; fwd_a = fwd_b = 2'b00.
- Pipeline flow: R-type in ID with rs=1, rt=2, rd=3 -> ex_dst=3 and ex_aluop=2'b10 at +1; mem_regwrite=1, mem_dst=3 at +2; wb_regwrite=1, wb_dst=3 at +3.
- Load-use, rs:
  - Stimulus: lw rt=5, followed by R-type rs=5.
  - Required response: stall=1 for exactly 1 cycle, and ID/EX takes a bubble.
  - When the R-type reaches EX: fwd_a=2'b01.
- Load-use, rt only: lw rt=4, then addi rt=4, rs=7 -> stall=0, since addi does not read rt. Repeat with sw rt=4 -> stall=1.
- Forwarding priority: add dst=6, add dst=6, then add rs=6, rt=6 -> fwd_a = fwd_b = 2'b10. Write to dst=0 -> mem_regwrite=0 and fwd_a=2'b00.
- Flush and jump:
  - flush=1 while lw hazard is present -> stall=0, if_flush=1, and ex_* and mem_* all 0 next cycle.
  - j in ID -> if_flush=1, and ex_aluop=2'b10 next cycle with all other ex_ bits 0.
